// File: rtl/ov5640_pkg.sv
// Shared types and default geometry for the OV5640 capture-to-memory path.
package ov5640_pkg;

    localparam int H_PIXEL_DEF   = 640;
    localparam int V_PIXEL_DEF   = 480;
    localparam int BURST_LEN_DEF = 64;

    typedef enum logic [1:0] {IDLE, REQ, DATA} wr_state_t;

    typedef logic [15:0] rgb565_t;

endpackage

// File: rtl/ov5640_sync_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy, flush and sticky overflow.
module ov5640_sync_fifo #(
    parameter int DEPTH = 256,
    parameter int WIDTH = 16
) (
    input  logic                     ov5640_pclk,
    input  logic                     sys_rst_n,
    input  logic                     flush,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     empty,
    output logic                     ovf,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [LW-1:0]    wr_ptr;
    logic [LW-1:0]    rd_ptr;
    logic             full;
    logic             push;
    logic             pop;

    assign level = wr_ptr - rd_ptr;
    assign empty = (level == '0);
    assign full  = (level == LW'(DEPTH));
    assign pop   = rd_en & ~empty;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign push  = wr_en & (~full | pop);

    assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge ov5640_pclk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            ovf    <= 1'b0;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
            end
            if (wr_en && full && !pop) ovf <= 1'b1;
        end
    end

    always_ff @(posedge ov5640_pclk) begin
        if (push && !flush) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/ov5640_wr_burst.sv
// Buffers captured RGB565 pixels and issues fixed-length, address-tagged write bursts,
// walking linearly through one frame and rewinding at frame end or on a VSYNC resync.
module ov5640_wr_burst
    import ov5640_pkg::*;
#(
    parameter int H_PIXEL    = H_PIXEL_DEF,
    parameter int V_PIXEL    = V_PIXEL_DEF,
    parameter int BURST_LEN  = BURST_LEN_DEF,
    parameter int FIFO_DEPTH = 256,
    parameter int ADDR_W     = 24,
    parameter int BASE_ADDR  = 0
) (
    input  logic                          ov5640_pclk,
    input  logic                          sys_rst_n,
    input  logic                          ov5640_vsync,
    input  logic                          ov5640_wr_en,
    input  logic [15:0]                   ov5640_data_out,
    output logic                          burst_req,
    output logic [ADDR_W-1:0]             burst_addr,
    input  logic                          burst_ack,
    output logic                          wr_data_valid,
    output logic [15:0]                   wr_data,
    input  logic                          wr_data_ready,
    output logic                          frame_done,
    output logic                          fifo_ovf,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] FRAME_END = ADDR_W'(BASE_ADDR + H_PIXEL * V_PIXEL);
    localparam logic [ADDR_W-1:0] BSTEP     = ADDR_W'(BURST_LEN);

    wr_state_t         state;
    logic [ADDR_W-1:0] addr_ptr;
    logic [BW-1:0]     beat_cnt;
    logic              vsync_q;
    logic              vsync_rise;
    logic              resync_pending;
    logic              flush;
    logic              fifo_empty;
    logic              beat;
    rgb565_t           head;

    assign vsync_rise    = ov5640_vsync & ~vsync_q;
    assign flush         = (state == IDLE) & resync_pending;
    assign wr_data_valid = (state == DATA) & ~fifo_empty;
    assign beat          = wr_data_valid & wr_data_ready;
    assign burst_addr    = addr_ptr;
    assign wr_data       = head;

    ov5640_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (16)
    ) u_fifo (
        .ov5640_pclk (ov5640_pclk),
        .sys_rst_n   (sys_rst_n),
        .flush       (flush),
        .wr_en       (ov5640_wr_en),
        .wr_data     (ov5640_data_out),
        .rd_en       (beat),
        .rd_data     (head),
        .empty       (fifo_empty),
        .ovf         (fifo_ovf),
        .level       (fifo_level)
    );

    always_ff @(posedge ov5640_pclk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state          <= IDLE;
            burst_req      <= 1'b0;
            addr_ptr       <= BASE;
            beat_cnt       <= '0;
            frame_done     <= 1'b0;
            vsync_q        <= 1'b0;
            resync_pending <= 1'b0;
        end else begin
            vsync_q    <= ov5640_vsync;
            frame_done <= 1'b0;
            if (vsync_rise) resync_pending <= 1'b1;
            case (state)
                IDLE: begin
                    // Resync only lands between bursts; a coincident edge re-arms it.
                    if (resync_pending) begin
                        addr_ptr       <= BASE;
                        resync_pending <= vsync_rise;
                    end else if (fifo_level >= LW'(BURST_LEN)) begin
                        state     <= REQ;
                        burst_req <= 1'b1;
                    end
                end
                REQ: begin
                    if (burst_ack) begin
                        state     <= DATA;
                        burst_req <= 1'b0;
                        beat_cnt  <= '0;
                    end
                end
                DATA: begin
                    if (beat) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        if (beat_cnt == BW'(BURST_LEN - 1)) begin
                            state <= IDLE;
                            if (addr_ptr + BSTEP == FRAME_END) begin
                                addr_ptr   <= BASE;
                                frame_done <= 1'b1;
                            end else begin
                                addr_ptr <= addr_ptr + BSTEP;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ov5640_wr_burst.sv
// Directed bench for ov5640_wr_burst; a 32x8 frame keeps the full-frame wrap case short.
module tb_ov5640_wr_burst;

    localparam int FRAME = 32 * 8;
    localparam int BL    = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        vsync = 1'b0;
    logic        wr_en = 1'b0;
    logic [15:0] din = '0;
    logic        burst_req;
    logic [23:0] burst_addr;
    logic        ack = 1'b0;
    logic        wr_data_valid;
    logic [15:0] wr_data;
    logic        ready = 1'b0;
    logic        frame_done;
    logic        fifo_ovf;
    logic [8:0]  fifo_level;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] pix = 16'h1000;
    logic [15:0] exp_data;
    int          exp_addr;
    int          bursts_seen, beats_seen, fd_seen, fd_beats;

    always #5 clk = ~clk;

    ov5640_wr_burst #(
        .H_PIXEL    (32),
        .V_PIXEL    (8),
        .BURST_LEN  (BL),
        .FIFO_DEPTH (256),
        .ADDR_W     (24),
        .BASE_ADDR  (0)
    ) dut (
        .ov5640_pclk     (clk),
        .sys_rst_n       (rst_n),
        .ov5640_vsync    (vsync),
        .ov5640_wr_en    (wr_en),
        .ov5640_data_out (din),
        .burst_req       (burst_req),
        .burst_addr      (burst_addr),
        .burst_ack       (ack),
        .wr_data_valid   (wr_data_valid),
        .wr_data         (wr_data),
        .wr_data_ready   (ready),
        .frame_done      (frame_done),
        .fifo_ovf        (fifo_ovf),
        .fifo_level      (fifo_level)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; wr_en = 1'b0; ack = 1'b0; ready = 1'b0; vsync = 1'b0;
        cyc(); cyc();
        rst_n = 1'b1;
        exp_data = pix; exp_addr = 0;
        bursts_seen = 0; beats_seen = 0; fd_seen = 0; fd_beats = -1;
        cyc();
    endtask

    task automatic write_px(input int n);
        for (int i = 0; i < n; i++) begin
            wr_en = 1'b1; din = pix; pix = pix + 16'd1;
            cyc();
        end
        wr_en = 1'b0;
    endtask

    // Consumer model: same-cycle ack, optional ready, optional concurrent writes.
    task automatic service(input int nwr, input logic rdy, input int ncyc);
        int w = 0;
        ready = rdy;
        for (int c = 0; c < ncyc; c++) begin
            if (burst_req) begin
                chk("burst_addr", 32'(burst_addr), 32'(exp_addr));
                bursts_seen++;
                exp_addr = (exp_addr + BL) % FRAME;
                ack = 1'b1;
            end else begin
                ack = 1'b0;
            end
            if (wr_data_valid && ready) begin
                chk("beat_data", 32'(wr_data), 32'(exp_data));
                exp_data = exp_data + 16'd1;
                beats_seen++;
            end
            if (frame_done) begin
                fd_seen++;
                fd_beats = beats_seen;
            end
            if (w < nwr) begin
                wr_en = 1'b1; din = pix; pix = pix + 16'd1; w++;
            end else begin
                wr_en = 1'b0;
            end
            cyc();
        end
        wr_en = 1'b0; ack = 1'b0;
    endtask

    initial begin
        // reset mid-burst, then first burst after release
        do_reset();
        chk("rst_level", 32'(fifo_level), 0);
        chk("rst_req", 32'(burst_req), 0);
        write_px(64);
        chk("lvl64", 32'(fifo_level), 64);
        chk("req_not_yet", 32'(burst_req), 0);
        cyc();
        chk("req_up", 32'(burst_req), 1);
        chk("req_addr0", 32'(burst_addr), 0);
        ack = 1'b1; cyc(); ack = 1'b0;
        chk("req_drop", 32'(burst_req), 0);
        ready = 1'b1;
        chk("valid_up", 32'(wr_data_valid), 1);
        chk("head0", 32'(wr_data), 32'(exp_data));
        repeat (10) cyc();
        chk("head10", 32'(wr_data), 32'(exp_data + 16'd10));
        chk("lvl54", 32'(fifo_level), 54);
        rst_n = 1'b0; #1;
        chk("ar_req", 32'(burst_req), 0);
        chk("ar_addr", 32'(burst_addr), 0);
        chk("ar_valid", 32'(wr_data_valid), 0);
        chk("ar_data", 32'(wr_data), 0);
        chk("ar_fd", 32'(frame_done), 0);
        chk("ar_ovf", 32'(fifo_ovf), 0);
        chk("ar_level", 32'(fifo_level), 0);
        do_reset();
        write_px(64);
        cyc();
        chk("post_rst_req", 32'(burst_req), 1);
        chk("post_rst_addr", 32'(burst_addr), 0);

        // 128 pixels, immediate ack, ready high
        do_reset();
        service(128, 1'b1, 400);
        chk("t2_bursts", 32'(bursts_seen), 2);
        chk("t2_beats", 32'(beats_seen), 128);
        chk("t2_fd", 32'(fd_seen), 0);
        chk("t2_level", 32'(fifo_level), 0);
        chk("t2_valid", 32'(wr_data_valid), 0);

        // full frame plus one burst: wrap back to base
        do_reset();
        service(FRAME + BL, 1'b1, 800);
        chk("t3_bursts", 32'(bursts_seen), 5);
        chk("t3_beats", 32'(beats_seen), 320);
        chk("t3_fd_count", 32'(fd_seen), 1);
        chk("t3_fd_pos", 32'(fd_beats), 32'(FRAME));

        // overflow with ready held low
        do_reset();
        write_px(256);
        chk("t4_lvl256", 32'(fifo_level), 256);
        chk("t4_no_ovf", 32'(fifo_ovf), 0);
        write_px(1);
        chk("t4_ovf", 32'(fifo_ovf), 1);
        chk("t4_lvl_hold", 32'(fifo_level), 256);
        write_px(3);
        chk("t4_lvl_hold2", 32'(fifo_level), 256);
        service(0, 1'b1, 500);
        chk("t4_bursts", 32'(bursts_seen), 4);
        chk("t4_beats", 32'(beats_seen), 256);
        chk("t4_drained", 32'(fifo_level), 0);
        chk("t4_ovf_sticky", 32'(fifo_ovf), 1);

        // VSYNC rise during DATA: burst finishes, remainder flushed
        do_reset();
        write_px(100);
        ack = 1'b1; cyc(); ack = 1'b0;
        vsync = 1'b1; cyc();
        service(0, 1'b1, 100);
        chk("t5_beats", 32'(beats_seen), 64);
        chk("t5_flushed", 32'(fifo_level), 0);
        chk("t5_idle", 32'(burst_req), 0);
        vsync = 1'b0; ready = 1'b0;
        write_px(64);
        cyc();
        chk("t5_req", 32'(burst_req), 1);
        chk("t5_addr0", 32'(burst_addr), 0);

        // full FIFO with simultaneous write and beat
        do_reset();
        write_px(256);
        ack = 1'b1; cyc(); ack = 1'b0;
        chk("t6_valid", 32'(wr_data_valid), 1);
        chk("t6_head", 32'(wr_data), 32'(exp_data));
        ready = 1'b1; wr_en = 1'b1; din = pix; pix = pix + 16'd1;
        cyc();
        ready = 1'b0; wr_en = 1'b0;
        chk("t6_level", 32'(fifo_level), 256);
        chk("t6_no_ovf", 32'(fifo_ovf), 0);
        chk("t6_head1", 32'(wr_data), 32'(exp_data + 16'd1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
